apb_req_arbiter: RTL and testbench



---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/apb_rr_pick.sv | 33 +++
 rtl/apb_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and default address window for the APB requester arbiter.
package apb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETUP,
    ACCESS,
    DONE,
    ERR
  } arb_state_e;

  localparam logic [31:0] DEF_WIN_BASE  = 32'h1000_0000;
  localparam logic [31:0] DEF_WIN_LIMIT = 32'h1000_4FFF;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set request bit after lastGrant, wrapping.
module apb_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_valid_o
);

  // Scan from the farthest candidate down to the nearest so the nearest set bit wins.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] candIdx;
    grant_o     = '0;
    any_valid_o = 1'b0;
    cand        = 0;
    candIdx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(last_grant_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      candIdx = cand[IDX_W-1:0];
      if (req_i[candIdx]) begin
        grant_o     = candIdx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master transfer port among NUM_REQ requesters,
// holding each grant until the transfer completes and rejecting out-of-window addresses locally.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int                NUM_REQ   = 2,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] WIN_BASE  = ADDR_W'(DEF_WIN_BASE),
  parameter logic [ADDR_W-1:0] WIN_LIMIT = ADDR_W'(DEF_WIN_LIMIT)
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          req_rdata,
  output logic                       req_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       m_transfer,
  output logic                       m_write,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_ready,
  input  logic [DATA_W-1:0]          m_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  lastGrant_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              errPhase_q;

  logic [IDX_W-1:0]  pickIdx;
  logic              anyValid;
  logic [ADDR_W-1:0] pickAddr;
  logic [DATA_W-1:0] pickWdata;
  logic              inWindow;

  apb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (lastGrant_q),
    .grant_o      (pickIdx),
    .any_valid_o  (anyValid)
  );

  assign pickAddr  = req_addr[pickIdx*ADDR_W +: ADDR_W];
  assign pickWdata = req_wdata[pickIdx*DATA_W +: DATA_W];
  assign inWindow  = (pickAddr >= WIN_BASE) && (pickAddr <= WIN_LIMIT);

  // State register; ERR spends one silent cycle before responding so errors complete at a fixed cycle 2.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      errPhase_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      errPhase_q <= (state_q == ERR) && !errPhase_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyValid) state_d = inWindow ? ISSUE : ERR;
      ISSUE:   state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (m_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     if (errPhase_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requester fields are latched once at grant; the live inputs are never looked at again.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      grant_q     <= '0;
      lastGrant_q <= IDX_W'(NUM_REQ - 1);
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      if (state_q == IDLE && anyValid) begin
        grant_q <= pickIdx;
        write_q <= req_write[pickIdx];
        addr_q  <= pickAddr;
        wdata_q <= pickWdata;
      end
      if (state_q == ACCESS && m_ready) begin
        rdata_q <= m_rdata;
      end
      if (state_q == DONE || (state_q == ERR && errPhase_q)) begin
        lastGrant_q <= grant_q;
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    req_rdata  = '0;
    req_err    = 1'b0;
    grant_id   = grant_q;
    busy       = (state_q != IDLE);
    m_transfer = 1'b0;
    m_write    = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    case (state_q)
      ISSUE: begin
        m_transfer = 1'b1;
        m_write    = write_q;
        m_addr     = addr_q;
        m_wdata    = wdata_q;
      end
      SETUP, ACCESS: begin
        m_write = write_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
      end
      DONE: begin
        m_write            = write_q;
        m_addr             = addr_q;
        m_wdata            = wdata_q;
        req_ready[grant_q] = 1'b1;
        req_rdata          = rdata_q;
      end
      ERR: begin
        if (errPhase_q) begin
          req_ready[grant_q] = 1'b1;
          req_err            = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a simple master/slave model answering m_transfer.
module tb_apb_req_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [31:0] req_rdata;
  logic        req_err;
  logic [0:0]  grant_id;
  logic        busy;
  logic        m_transfer;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic        slvTied = 1'b0;
  int          slvWaits = 0;
  logic [31:0] slvData = 32'h0;

  apb_req_arbiter dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .req_rdata  (req_rdata),
    .req_err    (req_err),
    .grant_id   (grant_id),
    .busy       (busy),
    .m_transfer (m_transfer),
    .m_write    (m_write),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Master+slave model: ready lands in the first ACCESS cycle plus slvWaits wait states.
  initial begin
    m_ready = 1'b0;
    m_rdata = 32'h0;
    forever begin
      tick();
      if (slvTied) begin
        m_ready = 1'b1;
        m_rdata = slvData;
      end else if (m_transfer) begin
        repeat (2 + slvWaits) tick();
        m_ready = 1'b1;
        m_rdata = slvData;
        tick();
        m_ready = 1'b0;
        m_rdata = 32'h0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic resetDut();
    PRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    slvTied   = 1'b0;
    slvWaits  = 0;
    repeat (2) tick();
    PRESET = 1'b0;
    tick();
  endtask

  task automatic waitTransfer(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      if (m_transfer) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
  endtask

  task automatic waitReady(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      if (req_ready != 2'b00) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    PRESET    = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr  = {32'h1000_0004, 32'h1000_0000};
    req_wdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tick();
    testsRun++;
    if ({req_ready, req_err, busy, m_transfer, m_write, grant_id} !== 7'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {req_ready, req_err, busy, m_transfer, m_write, grant_id});
    end
    testsRun++;
    if ({req_rdata, m_addr, m_wdata} !== 96'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got rdata=%h addr=%h wdata=%h expected all 0",
               req_rdata, m_addr, m_wdata);
    end
    req_valid = '0;
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    resetDut();
    slvData   = 32'hDEAD_BEEF;
    req_addr[31:0] = 32'h1000_1004;
    req_write = 2'b00;
    req_valid = 2'b01;
    testsRun++;
    if (m_transfer !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL t1_cycle0: got transfer=%b busy=%b expected 0 0", m_transfer, busy);
    end
    tick();
    testsRun++;
    if (m_transfer !== 1'b1 || m_addr !== 32'h1000_1004 || m_write !== 1'b0 || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL t1_cycle1: got transfer=%b addr=%h write=%b busy=%b expected 1 10001004 0 1",
               m_transfer, m_addr, m_write, busy);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      testsRun++;
      if (req_ready !== 2'b00 || m_transfer !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL t1_early_c%0d: got ready=%b transfer=%b expected 00 0", c, req_ready, m_transfer);
      end
    end
    tick();
    testsRun++;
    if (req_ready !== 2'b01 || req_rdata !== 32'hDEAD_BEEF || req_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL t1_cycle4: got ready=%b rdata=%h err=%b expected 01 deadbeef 0",
               req_ready, req_rdata, req_err);
    end
    req_valid = 2'b00;
    tick();
    testsRun++;
    if (req_ready !== 2'b00 || busy !== 1'b0 || m_addr !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL t1_idle: got ready=%b busy=%b addr=%h expected 00 0 0", req_ready, busy, m_addr);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    bit seen;
    int exp;
    logic [31:0] expAddr;
    logic [31:0] expData;
    resetDut();
    slvData   = 32'h0;
    req_addr  = {32'h1000_2000, 32'h1000_0000};
    req_wdata = {32'h2222_2222, 32'h1111_1111};
    req_write = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp     = k % 2;
      expAddr = (exp == 0) ? 32'h1000_0000 : 32'h1000_2000;
      expData = (exp == 0) ? 32'h1111_1111 : 32'h2222_2222;
      waitTransfer(cyc, seen);
      testsRun++;
      if (!seen || cyc != ((k == 0) ? 1 : 2)) begin
        testsFailed++;
        $display("[TB] FAIL rr_issue_gap_%0d: got seen=%b after %0d cycles expected %0d", k, seen, cyc,
                 (k == 0) ? 1 : 2);
      end
      testsRun++;
      if (grant_id !== exp[0] || m_addr !== expAddr || m_wdata !== expData || m_write !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL rr_grant_%0d: got id=%0d addr=%h wdata=%h write=%b expected %0d %h %h 1",
                 k, grant_id, m_addr, m_wdata, m_write, exp, expAddr, expData);
      end
      waitReady(cyc, seen);
      testsRun++;
      if (!seen || req_ready !== (2'b01 << exp)) begin
        testsFailed++;
        $display("[TB] FAIL rr_ready_%0d: got seen=%b ready=%b expected %b", k, seen, req_ready,
                 2'b01 << exp);
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_wait_states();
    resetDut();
    slvWaits  = 3;
    slvData   = 32'h0000_0077;
    req_addr[31:0]  = 32'h1000_3008;
    req_wdata[31:0] = 32'hCAFE_F00D;
    req_write = 2'b01;
    req_valid = 2'b01;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 2) begin
        req_valid = 2'b00;
        req_addr[31:0]  = 32'hFFFF_FFFF;
        req_wdata[31:0] = 32'h0;
        req_write = 2'b00;
      end
      testsRun++;
      if (m_addr !== 32'h1000_3008 || m_wdata !== 32'hCAFE_F00D || m_write !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL ws_stable_c%0d: got addr=%h wdata=%h write=%b expected 10003008 cafef00d 1",
                 c, m_addr, m_wdata, m_write);
      end
      testsRun++;
      if (req_ready !== ((c == 7) ? 2'b01 : 2'b00) || m_transfer !== (c == 1)) begin
        testsFailed++;
        $display("[TB] FAIL ws_ctrl_c%0d: got ready=%b transfer=%b expected %b %b",
                 c, req_ready, m_transfer, (c == 7) ? 2'b01 : 2'b00, c == 1);
      end
    end
    tick();
    testsRun++;
    if (busy !== 1'b0 || m_addr !== 32'h0 || req_ready !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL ws_after: got busy=%b addr=%h ready=%b expected 0 0 00", busy, m_addr, req_ready);
    end
  endtask

  task automatic test_addr_window();
    int cyc;
    bit seen;
    logic [31:0] edgeAddr [4];
    logic        edgeErr  [4];
    resetDut();
    slvData   = 32'h5555_0000;
    req_addr[31:0] = 32'h2000_0000;
    req_write = 2'b00;
    req_valid = 2'b01;
    tick();
    testsRun++;
    if (m_transfer !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL err_c1: got transfer=%b busy=%b ready=%b expected 0 1 00", m_transfer, busy, req_ready);
    end
    tick();
    testsRun++;
    if (req_ready !== 2'b01 || req_err !== 1'b1 || req_rdata !== 32'h0 || m_transfer !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL err_c2: got ready=%b err=%b rdata=%h transfer=%b expected 01 1 0 0",
               req_ready, req_err, req_rdata, m_transfer);
    end
    req_valid = 2'b00;
    tick();
    slvData   = 32'h0BAD_F00D;
    req_addr[31:0] = 32'h1000_4000;
    req_valid = 2'b01;
    waitTransfer(cyc, seen);
    testsRun++;
    if (!seen || cyc != 1) begin
      testsFailed++;
      $display("[TB] FAIL err_next_issue: got seen=%b cycles=%0d expected 1 1", seen, cyc);
    end
    waitReady(cyc, seen);
    testsRun++;
    if (!seen || req_err !== 1'b0 || req_rdata !== 32'h0BAD_F00D) begin
      testsFailed++;
      $display("[TB] FAIL err_next_done: got seen=%b err=%b rdata=%h expected 1 0 0badf00d",
               seen, req_err, req_rdata);
    end
    req_valid = 2'b00;
    tick();
    edgeAddr[0] = 32'h1000_4FFF; edgeErr[0] = 1'b0;
    edgeAddr[1] = 32'h0FFF_FFFF; edgeErr[1] = 1'b1;
    edgeAddr[2] = 32'h1000_0000; edgeErr[2] = 1'b0;
    edgeAddr[3] = 32'h1000_5000; edgeErr[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[31:0] = edgeAddr[i];
      req_valid = 2'b01;
      waitReady(cyc, seen);
      testsRun++;
      if (!seen || req_err !== edgeErr[i] || req_rdata !== (edgeErr[i] ? 32'h0 : 32'h0BAD_F00D)) begin
        testsFailed++;
        $display("[TB] FAIL window_%h: got seen=%b err=%b rdata=%h expected err=%b",
                 edgeAddr[i], seen, req_err, req_rdata, edgeErr[i]);
      end
      req_valid = 2'b00;
      tick();
    end
  endtask

  task automatic test_ready_tied();
    resetDut();
    slvData   = 32'h5A5A_0001;
    slvTied   = 1'b1;
    m_ready   = 1'b1;
    req_addr[31:0] = 32'h1000_0010;
    req_write = 2'b00;
    req_valid = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      tick();
      testsRun++;
      if (req_ready !== ((c == 4) ? 2'b01 : 2'b00)) begin
        testsFailed++;
        $display("[TB] FAIL tied_c%0d: got ready=%b expected %b", c, req_ready, (c == 4) ? 2'b01 : 2'b00);
      end
    end
    testsRun++;
    if (req_rdata !== 32'h5A5A_0001) begin
      testsFailed++;
      $display("[TB] FAIL tied_rdata: got %h expected 5a5a0001", req_rdata);
    end
    req_valid = 2'b00;
    slvTied   = 1'b0;
    m_ready   = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    bit seen;
    bit sawReady;
    resetDut();
    slvData   = 32'h0000_1234;
    req_addr  = {32'h1000_0200, 32'h1000_0100};
    req_write = 2'b00;
    req_valid = 2'b01;
    waitReady(cyc, seen);
    req_valid = 2'b00;
    tick();
    slvWaits  = 6;
    req_valid = 2'b10;
    waitTransfer(cyc, seen);
    testsRun++;
    if (!seen || grant_id !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_pre_grant: got seen=%b id=%0d expected 1 1", seen, grant_id);
    end
    repeat (3) tick();
    PRESET = 1'b1;
    #1;
    testsRun++;
    if ({busy, m_transfer, m_write, grant_id, req_ready, req_err} !== 7'b0 || m_addr !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL rst_async: got ctrl=%b addr=%h expected 0000000 0",
               {busy, m_transfer, m_write, grant_id, req_ready, req_err}, m_addr);
    end
    sawReady = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (req_ready != 2'b00) sawReady = 1'b1;
    end
    testsRun++;
    if (sawReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_no_ready: got pulse=%b expected 0", sawReady);
    end
    slvWaits  = 0;
    req_valid = 2'b11;
    PRESET    = 1'b0;
    waitTransfer(cyc, seen);
    testsRun++;
    if (!seen || grant_id !== 1'b0 || m_addr !== 32'h1000_0100) begin
      testsFailed++;
      $display("[TB] FAIL rst_first_grant: got seen=%b id=%0d addr=%h expected 1 0 10000100",
               seen, grant_id, m_addr);
    end
    waitReady(cyc, seen);
    testsRun++;
    if (!seen || req_ready !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL rst_first_done: got seen=%b ready=%b expected 1 01", seen, req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    PRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_addr_window();
    test_ready_tied();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
